// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a; stall handling lives in pc_seq_unit.
// Contents: next-PC source encoding and the default parameter values.
package pc_pkg;

   // Which source feeds the PC register on the coming edge.
   typedef enum logic [2:0] {
      SRC_HOLD = 3'd0,
      SRC_SEQ  = 3'd1,
      SRC_BR   = 3'd2,
      SRC_JMP  = 3'd3,
      SRC_CALL = 3'd4,
      SRC_RET  = 3'd5
   } src_e;

   localparam int DEF_AW        = 5;
   localparam int DEF_STEP      = 4;
   localparam int DEF_LIMIT     = 31;
   localparam int DEF_RESET_PC  = 0;
   localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack with drop-oldest overflow and error pulse.
// Latency: push/pop visible on count/top one cycle after the edge; err lasts one cycle.
// Backpressure: none; push when full discards the oldest entry, pop when empty is a no-op.
// Ports: clk, rst (sync, active-high), push, pop, push_data -> top, count, err.
module pc_ras
   import pc_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               push,
   input  logic                               pop,
   input  logic [AW-1:0]                      push_data,
   output logic [AW-1:0]                      top,
   output logic [$clog2(RAS_DEPTH+1)-1:0]     count,
   output logic                               err
);

   localparam int CW = $clog2(RAS_DEPTH+1);

   // Entry 0 is the oldest; entry count-1 is the top.
   logic [AW-1:0] stack [RAS_DEPTH];
   logic          full;
   logic          empty;

   assign full  = (count == CW'(RAS_DEPTH));
   assign empty = (count == '0);

   always_comb begin
      top = '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
         if (CW'(i) + CW'(1) == count) begin
            top = stack[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         err   <= 1'b0;
      end else begin
         err <= (push && full) || (pop && empty);
         if (push && !full) begin
            count <= count + CW'(1);
         end else if (pop && !empty) begin
            count <= count - CW'(1);
         end
      end
   end

   // Contents need no reset: count alone decides which entries are valid.
   // On overflow everything shifts one slot toward the bottom, losing entry 0,
   // and the new address lands in the topmost slot.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            if (full) begin
               if (i == RAS_DEPTH - 1) begin
                  stack[i] <= push_data;
               end else begin
                  stack[i] <= stack[(i + 1) % RAS_DEPTH];
               end
            end else if (CW'(i) == count) begin
               stack[i] <= push_data;
            end
         end
      end
   end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program counter with stall, branch/jump redirect and call/return via a RAS.
// Latency: one cycle from sampled request to pc_out / ras_count.
// Backpressure: stall freezes PC and RAS and masks every other request (reset still wins).
// Ports: clk, rst, stall, br_taken/br_target, jmp/jmp_target, call, ret
//        -> pc_out, ras_count, ras_full, ras_empty, ras_err.
module pc_seq_unit
   import pc_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int STEP      = DEF_STEP,
   parameter int LIMIT     = DEF_LIMIT,
   parameter int RESET_PC  = DEF_RESET_PC,
   parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               stall,
   input  logic                               br_taken,
   input  logic [AW-1:0]                      br_target,
   input  logic                               jmp,
   input  logic [AW-1:0]                      jmp_target,
   input  logic                               call,
   input  logic                               ret,
   output logic [AW-1:0]                      pc_out,
   output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
   output logic                               ras_full,
   output logic                               ras_empty,
   output logic                               ras_err
);

   localparam int CW = $clog2(RAS_DEPTH+1);

   src_e          src;
   logic [AW-1:0] seq_pc;
   logic [AW-1:0] ret_addr;
   logic [AW-1:0] ras_top;
   logic [AW-1:0] pc_next;
   logic          ras_push;
   logic          ras_pop;

   // Carry out of the adds is dropped on purpose: the PC space is mod 2^AW.
   assign seq_pc   = (pc_out == AW'(LIMIT)) ? AW'(RESET_PC) : pc_out + AW'(STEP);
   // The return address ignores the LIMIT wrap; it is simply the next slot.
   assign ret_addr = pc_out + AW'(STEP);

   assign ras_full  = (ras_count == CW'(RAS_DEPTH));
   assign ras_empty = (ras_count == '0);

   always_comb begin
      src = SRC_SEQ;
      if (stall) begin
         src = SRC_HOLD;
      end else if (ret) begin
         // Underflowing return falls through to the sequential path.
         src = ras_empty ? SRC_SEQ : SRC_RET;
      end else if (call) begin
         src = SRC_CALL;
      end else if (jmp) begin
         src = SRC_JMP;
      end else if (br_taken) begin
         src = SRC_BR;
      end
   end

   // Pop is issued even on an empty stack so the RAS can flag the underflow.
   assign ras_push = (src == SRC_CALL);
   assign ras_pop  = !stall && ret;

   always_comb begin
      pc_next = seq_pc;
      case (src)
         SRC_HOLD: pc_next = pc_out;
         SRC_SEQ:  pc_next = seq_pc;
         SRC_BR:   pc_next = br_target;
         SRC_JMP:  pc_next = jmp_target;
         SRC_CALL: pc_next = jmp_target;
         SRC_RET:  pc_next = ras_top;
         default:  pc_next = seq_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_out <= AW'(RESET_PC);
      end else begin
         pc_out <= pc_next;
      end
   end

   pc_ras #(
      .AW        (AW),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (ret_addr),
      .top       (ras_top),
      .count     (ras_count),
      .err       (ras_err)
   );

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit at default parameters.
// Vectors carry inputs plus expected outputs; expectations are queued when driven
// and popped for comparison one cycle later, after the edge.
module tb_pc_seq_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       stall;
   logic       br_taken;
   logic [4:0] br_target;
   logic       jmp;
   logic [4:0] jmp_target;
   logic       call;
   logic       ret;
   logic [4:0] pc_out;
   logic [2:0] ras_count;
   logic       ras_full;
   logic       ras_empty;
   logic       ras_err;

   int checks = 0;
   int errors = 0;
   int nstep  = 0;

   always #5 clk = ~clk;

   pc_seq_unit dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .call       (call),
      .ret        (ret),
      .pc_out     (pc_out),
      .ras_count  (ras_count),
      .ras_full   (ras_full),
      .ras_empty  (ras_empty),
      .ras_err    (ras_err)
   );

   typedef struct {
      logic       rst;
      logic       stall;
      logic       br;
      logic [4:0] bt;
      logic       jmp;
      logic [4:0] jt;
      logic       call;
      logic       ret;
      logic [4:0] epc;
      logic [2:0] ecnt;
      logic       eerr;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   function automatic vec_t mk(input logic r, input logic s, input logic b, input int bt,
                               input logic j, input int jt, input logic c, input logic rt,
                               input int epc, input int ecnt, input logic eerr);
      vec_t v;
      v.rst = r;  v.stall = s; v.br = b;  v.bt = 5'(bt);
      v.jmp = j;  v.jt = 5'(jt); v.call = c; v.ret = rt;
      v.epc = 5'(epc); v.ecnt = 3'(ecnt); v.eerr = eerr;
      return v;
   endfunction

   task automatic chk(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at step %0d: got %0d, expected %0d", what, idx, act, exp);
      end
   endtask

   // Drive one vector, queue its expectation, compare after the edge.
   task automatic step(input vec_t v);
      vec_t e;
      rst = v.rst; stall = v.stall; br_taken = v.br; br_target = v.bt;
      jmp = v.jmp; jmp_target = v.jt; call = v.call; ret = v.ret;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      nstep++;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", nstep, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("pc_out",    nstep, 32'(pc_out),    32'(e.epc));
         chk("ras_count", nstep, 32'(ras_count), 32'(e.ecnt));
         chk("ras_full",  nstep, 32'(ras_full),  32'(e.ecnt == 3'd4));
         chk("ras_empty", nstep, 32'(ras_empty), 32'(e.ecnt == 3'd0));
         chk("ras_err",   nstep, 32'(ras_err),   32'(e.eerr));
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
      jmp = 1'b0; jmp_target = '0; call = 1'b0; ret = 1'b0;

      //             rst st br bt  jmp jt cal ret  pc  cnt err
      // reset, then free run with wrap at 28 -> 0
      tbl.push_back(mk(1, 0, 0, 0,  0, 0,  0, 0,   0,  0, 0));
      tbl.push_back(mk(1, 0, 0, 0,  0, 0,  0, 0,   0,  0, 0));
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, (k * 4) % 32, 0, 0));
      // branch to LIMIT, then LIMIT wraps to RESET_PC
      tbl.push_back(mk(0, 0, 1, 31, 0, 0,  0, 0,  31,  0, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,   0,  0, 0));
      // stall with a pending branch
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,   4,  0, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,   8,  0, 0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0, 1, 1, 20, 0, 0, 0, 0, 8, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,  12,  0, 0));
      // call / idle / return
      tbl.push_back(mk(0, 0, 0, 0,  0, 20, 1, 0,  20,  1, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,  24,  1, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 1,  16,  0, 0));
      // overflow: calls from 0,4,8,12,16
      tbl.push_back(mk(0, 0, 0, 0,  1, 0,  0, 0,   0,  0, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 4,  1, 0,   4,  1, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 8,  1, 0,   8,  2, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 12, 1, 0,  12,  3, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 16, 1, 0,  16,  4, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 28, 1, 0,  28,  4, 1));
      // four returns drain newest first (return address 4 was dropped), then underflow
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 1,  20,  3, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 1,  16,  2, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 1,  12,  1, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 1,   8,  0, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 1,  12,  0, 1));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,  16,  0, 0));
      // simultaneous requests: ret wins with one entry (16) stacked
      tbl.push_back(mk(0, 0, 0, 0,  1, 12, 0, 0,  12,  0, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  1, 0,   0,  1, 0));
      tbl.push_back(mk(0, 0, 1, 8,  1, 4,  1, 1,  16,  0, 0));
      // jmp beats br; call at LIMIT pushes 31+4 mod 32 = 3 with no LIMIT wrap
      tbl.push_back(mk(0, 0, 1, 20, 1, 10, 0, 0,  10,  0, 0));
      tbl.push_back(mk(0, 0, 1, 31, 0, 0,  0, 0,  31,  0, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  1, 0,   0,  1, 0));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,  0, 1,   3,  0, 0));

      foreach (tbl[i]) step(tbl[i]);

      // Held ret over two edges pops twice; a stalled ret pops nothing.
      step(mk(0, 0, 0, 0, 0, 20, 1, 0, 20, 1, 0));
      step(mk(0, 0, 0, 0, 0, 8,  1, 0,  8, 2, 0));
      step(mk(0, 1, 0, 0, 0, 0,  0, 1,  8, 2, 0));
      step(mk(0, 0, 0, 0, 0, 0,  0, 1, 24, 1, 0));
      step(mk(0, 0, 0, 0, 0, 0,  0, 1,  7, 0, 0));

      // Reset while stalled with three entries stacked.
      step(mk(0, 0, 0, 0, 0, 4,  1, 0,  4, 1, 0));
      step(mk(0, 0, 0, 0, 0, 8,  1, 0,  8, 2, 0));
      step(mk(0, 0, 0, 0, 0, 12, 1, 0, 12, 3, 0));
      step(mk(1, 1, 0, 0, 0, 0,  0, 1,  0, 0, 0));
      step(mk(0, 0, 0, 0, 0, 0,  0, 0,  4, 0, 0));

      // Reset on the same edge as an underflowing ret suppresses the error pulse.
      step(mk(0, 0, 0, 0, 0, 0,  0, 1,  8, 0, 1));
      step(mk(1, 0, 0, 0, 0, 0,  0, 1,  0, 0, 0));
      step(mk(0, 0, 0, 0, 0, 0,  0, 0,  4, 0, 0));

      if (exp_q.size() != 0) begin
         chk("scoreboard_leftover", nstep, 32'(exp_q.size()), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter unit for the fetch stage, the next generation of the fixed 5-bit, step-4 PC. It adds synchronous reset, stall, branch and jump redirection, and call/return through an internal return-address stack (RAS). It sits between the control unit, which supplies the redirect requests, and instruction memory, which is addressed by `pc_out`.

## Interface
- `AW`, 5: PC width in bits.
- `STEP`, 4: sequential increment.
- `LIMIT`, 31: PC value that wraps to `RESET_PC` on a sequential advance.
- `RESET_PC`, 0: value loaded on reset and on wrap.
- `RAS_DEPTH`, 4: return-stack entries (≥1).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold PC and RAS; all requests are ignored.
- `br_taken` in 1, `br_target` in AW: conditional branch redirect.
- `jmp` in 1, `jmp_target` in AW: unconditional jump.
- `call` in 1: jump to `jmp_target` and push the return address.
- `ret` in 1: pop the RAS and jump to the popped address.
- `pc_out` out AW: current PC (registered).
- `ras_count` out $clog2(RAS_DEPTH+1): number of valid entries.
- `ras_full`, `ras_empty` out 1: combinational decode of `ras_count`.
- `ras_err` out 1: one-cycle pulse on push-when-full or pop-when-empty.

## Operation
- **Sequential next:** `seq = (pc_out == LIMIT) ? RESET_PC : pc_out + STEP`, computed mod 2^AW. Carry out is discarded.
- **Priority per edge:** rst > stall > ret > call > jmp > br_taken > seq. Only the winning request acts; losing requests have no effect.
- **rst:**
  - `pc_out` = RESET_PC.
  - `ras_count` = 0, `ras_empty` = 1, `ras_full` = 0, `ras_err` = 0.
  - RAS contents are don't-care.
  - rst overrides every other input, including in the middle of a call or return sequence.
- **stall:** `pc_out` and the RAS hold; `ras_err` = 0.
- **ret, not empty:** `pc_out` = top entry; `ras_count` − 1.
- **ret, empty:** `pc_out` = seq; `ras_err` pulses.
- **call:**
  - Push `pc_out` + STEP (mod 2^AW; LIMIT wrap not applied).
  - `pc_out` = `jmp_target`.
- **call, RAS full:**
  - Oldest entry is discarded; the stack shifts.
  - New entry goes on top; `ras_count` stays RAS_DEPTH.
  - `ras_err` pulses; the jump still occurs.
- **jmp:** `pc_out` = `jmp_target`.
- **br_taken:** `pc_out` = `br_target`.
- **Otherwise:** `pc_out` = seq.
- **`ras_err`** is 0 on every edge without an error condition.

## Timing
- All outputs are registered except `ras_full` and `ras_empty`, which decode the registered `ras_count`.
- Latency is one cycle: requests sampled at edge N are visible on `pc_out` and `ras_count` after edge N.
- The `ras_err` pulse is visible for the cycle after the offending edge.
- There is no handshake; request inputs are level-sampled each edge. Holding `ret` for two cycles performs two pops.
- After rst deasserts, the first edge advances from RESET_PC.

## Structure
- Shared package/include `pc_pkg`:
  - Next-PC source encoding: SRC_HOLD, SRC_SEQ, SRC_BR, SRC_JMP, SRC_CALL, SRC_RET.
  - Default parameter constants.
- Sub-module `pc_ras`:
  - Parametrised by AW and RAS_DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: top, count, err; implements the drop-oldest rule.
- Top level `pc_seq_unit`: priority select, seq adder, PC register.

## Test plan
All scenarios use default parameters.
- **Reset and free run:** rst for 2 cycles, then idle → `pc_out` reads 0, 4, 8, …, 28, 0. On branch to 31 the next two values are 31 then 0.
- **Stall:** at `pc_out`=8, assert stall for 3 cycles with `br_taken`=1, `br_target`=20 → `pc_out` stays 8 for 3 cycles, then 12 (branch ignored once released).
- **Call/return:**
  - At `pc_out`=12: call with `jmp_target`=20 → `pc_out`=20, `ras_count`=1.
  - Idle one cycle → 24.
  - ret → `pc_out`=16, `ras_count`=0, `ras_empty`=1.
- **RAS overflow/underflow:**
  - Five calls from PCs 0, 4, 8, 12, 16 → `ras_full` after the 4th; 5th gives a `ras_err` pulse and `ras_count`=4.
  - Four rets → 20, 16, 12, 8.
  - Fifth ret → `ras_err` pulse and sequential advance.
- **Simultaneous requests:** with `ras_count`=1 (top=16), assert ret+call+jmp+`br_taken` together → `pc_out`=16, `ras_count`=0.
- **Reset mid-operation:** with `ras_count`=3 and stall=1, assert rst → next cycle `pc_out`=0, `ras_count`=0, `ras_err`=0.
